piso_serializer: RTL and testbench

- Parallel-in/serial-out stage directly upstream of the 10010 Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register.
- Shifts words out one bit per enabled clock on `j`, which drives the detector's serial input.
- Gapless streaming of back-to-back words, with a pause enable and an end-of-word pulse.

---
 rtl/piso_serializer.sv | 137 +++++++++++++
 tb/tb_piso_serializer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: one-word holding register behind a valid/ready
// handshake, feeding a shift register that streams one bit per enabled clock on j.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             j,
  output logic             j_valid,
  output logic             word_done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             j_reg, j_next;
  logic             word_done_reg, word_done_next;

  logic             accept;
  logic             load;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sh_adv;

  // The shift register rotates rather than shifts so every bit stays observed;
  // only the WIDTH bits of the current word are ever presented on j.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit = hold_reg[WIDTH-1];
      assign next_bit  = sh_reg[WIDTH-2];
      assign sh_adv    = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
    end else begin : g_lsb
      assign first_bit = hold_reg[0];
      assign next_bit  = sh_reg[1];
      assign sh_adv    = {sh_reg[0], sh_reg[WIDTH-1:1]};
    end
  endgenerate

  assign din_ready = ~hold_full_reg & ~rst;
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    sh_next        = sh_reg;
    cnt_next       = cnt_reg;
    j_next         = j_reg;
    word_done_next = 1'b0;
    load           = 1'b0;

    case (state_reg)
      IDLE: begin
        j_next = IDLE_BIT;
        if (en && hold_full_reg) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_reg == LAST_CNT) begin
            word_done_next = 1'b1;
            if (hold_full_reg) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
              j_next     = IDLE_BIT;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
            sh_next  = sh_adv;
            j_next   = next_bit;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Load and accept are mutually exclusive: load needs a full holding
    // register, accept needs an empty one.
    if (load) begin
      sh_next        = hold_reg;
      hold_full_next = 1'b0;
      cnt_next       = '0;
      state_next     = SHIFT;
      j_next         = first_bit;
    end

    if (accept) begin
      hold_next      = din;
      hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      sh_reg        <= '0;
      cnt_reg       <= '0;
      j_reg         <= IDLE_BIT;
      word_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      sh_reg        <= sh_next;
      cnt_reg       <= cnt_next;
      j_reg         <= j_next;
      word_done_reg <= word_done_next;
    end
  end

  assign j         = j_reg;
  assign j_valid   = (state_reg == SHIFT);
  assign word_done = word_done_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a word-queue model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       en;
  logic       ready0, j0, jv0, wd0;
  logic       ready1, j1, jv1, wd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready0),
    .en(en), .j(j0), .j_valid(jv0), .word_done(wd0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready1),
    .en(en), .j(j1), .j_valid(jv1), .word_done(wd1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words wait in a queue (at most one), the active
  // word is presented bit by bit, one bit consumed per enabled edge.
  logic [7:0] m_wq[$];
  logic [7:0] m_cur    = 8'h00;
  int         m_idx    = 0;
  logic       m_active = 1'b0;
  logic       m_done   = 1'b0;
  logic       m_acc;
  logic       chk_on   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_wq.delete();
      m_active = 1'b0;
      m_idx    = 0;
      m_done   = 1'b0;
    end else begin
      m_acc  = din_valid && (m_wq.size() == 0);
      m_done = 1'b0;
      if (m_active && en) begin
        m_idx++;
        if (m_idx == 8) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
      if (en && !m_active && m_wq.size() > 0) begin
        m_cur    = m_wq.pop_front();
        m_idx    = 0;
        m_active = 1'b1;
      end
      if (m_acc) m_wq.push_back(din);
    end
  end

  function automatic logic exp_bit(input logic msb, input logic idle);
    if (!m_active || m_idx > 7) return idle;
    return msb ? m_cur[7 - m_idx] : m_cur[m_idx];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("din_ready_msb", ready0, (m_wq.size() == 0) && !rst);
      check("din_ready_lsb", ready1, (m_wq.size() == 0) && !rst);
      check("j_valid_msb", jv0, m_active);
      check("j_valid_lsb", jv1, m_active);
      check("j_msb", j0, exp_bit(1'b1, 1'b0));
      check("j_lsb", j1, exp_bit(1'b0, 1'b1));
      check("word_done_msb", wd0, m_done);
      check("word_done_lsb", wd1, m_done);
    end
  end

  // Stream monitor used by the directed literal checks.
  int   cyc = 0;
  logic mon_on = 1'b0;
  logic q0[$];
  logic q1[$];
  int   jvc[$];
  int   wdc[$];

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (jv0) begin
        q0.push_back(j0);
        jvc.push_back(cyc);
      end
      if (jv1) q1.push_back(j1);
      if (wd0) wdc.push_back(cyc);
    end
  end

  function automatic logic [31:0] seq(input logic q[$], input int from, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[30:0], (from + i < q.size()) ? q[from + i] : 1'b0};
    end
    return r;
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic mon_clear();
    q0.delete();
    q1.delete();
    jvc.delete();
    wdc.delete();
    mon_on = 1'b1;
  endtask

  logic en_rand = 1'b0;

  task automatic step();
    @(negedge clk);
    #2;
    if (en_rand) en = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0] w, output int waits);
    logic got;
    din       = w;
    din_valid = 1'b1;
    waits     = 0;
    got       = 1'b0;
    for (int tries = 0; tries < 200 && !got; tries++) begin
      #1;
      got = ready0;
      if (!got) waits++;
      step();
    end
    din_valid = 1'b0;
    din       = 8'($urandom);
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_jv();
    logic seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      if (jv0) seen = 1'b1;
      else step();
    end
    if (!seen) check("wait_j_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n_rand;
    rst       = 1'b1;
    en        = 1'b1;
    din       = 8'hEE;
    din_valid = 1'b1;
    step();
    chk_on = 1'b1;
    #1 check("ready_in_reset", ready0, 1'b0);
    step();
    step();

    // Reset state
    din_valid = 1'b0;
    rst       = 1'b0;
    #1;
    check("rst_ready", ready0, 1'b1);
    check("rst_j_valid", jv0, 1'b0);
    check("rst_j_msb", j0, 1'b0);
    check("rst_j_lsb", j1, 1'b1);
    check("rst_word_done", wd0, 1'b0);
    step();
    step();

    // Single word, MSB first, plus capture-to-output latency
    mon_clear();
    send(8'h90, w);
    check("latency_idle", jv0, 1'b0);
    step();
    check("latency_valid", jv0, 1'b1);
    check("latency_first_msb", j0, 1'b1);
    check("latency_first_lsb", j1, 1'b0);
    repeat (11) step();
    check("msb_stream_90", seq(q0, 0, 8), 32'h90);
    check("lsb_stream_90", seq(q1, 0, 8), 32'h09);
    check("single_bits", jvc.size(), 8);
    check("single_done_count", wdc.size(), 1);
    check("single_done_pos", at(wdc, 0) - at(jvc, 0), 8);

    // LSB-first instance on 8'b0000_1001 -> 1,0,0,1,0,0,0,0
    mon_clear();
    send(8'h09, w);
    repeat (12) step();
    check("lsb_stream_09", seq(q1, 0, 8), 32'h90);
    check("msb_stream_09", seq(q0, 0, 8), 32'h09);

    // Back-to-back words plus backpressure on a third
    mon_clear();
    send(8'hA5, w);
    send(8'h3C, w);
    check("b2b_second_waits", w, 1);
    send(8'hFF, w);
    check("backpressure_waits", w, 7);
    repeat (30) step();
    check("b2b_word1", seq(q0, 0, 8), 32'hA5);
    check("b2b_word2", seq(q0, 8, 8), 32'h3C);
    check("b2b_word3", seq(q0, 16, 8), 32'hFF);
    check("b2b_valid_cycles", jvc.size(), 24);
    check("b2b_no_gap", at(jvc, 23) - at(jvc, 0), 23);
    check("b2b_done_count", wdc.size(), 3);
    check("b2b_done_spacing1", at(wdc, 1) - at(wdc, 0), 8);
    check("b2b_done_spacing2", at(wdc, 2) - at(wdc, 1), 8);

    // Pause after bit 2 of 8'hC3
    mon_clear();
    send(8'hC3, w);
    wait_jv();
    step();
    step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (12) step();
    check("pause_valid_cycles", jvc.size(), 11);
    check("pause_stream", seq(q0, 0, 11), 32'b110_0000_0011);
    check("pause_done_count", wdc.size(), 1);

    // Reset mid-word with a second word held
    send(8'hF0, w);
    send(8'h5A, w);
    wait_jv();
    repeat (4) step();
    rst = 1'b1;
    #1 check("midrst_ready_low", ready0, 1'b0);
    step();
    check("midrst_j_valid", jv0, 1'b0);
    check("midrst_j_msb", j0, 1'b0);
    check("midrst_j_lsb", j1, 1'b1);
    check("midrst_word_done", wd0, 1'b0);
    rst = 1'b0;
    #1 check("midrst_ready_after", ready0, 1'b1);
    mon_clear();
    repeat (12) step();
    check("midrst_held_word_lost", jvc.size(), 0);

    // Randomized traffic with random enable and idle gaps
    mon_clear();
    en_rand = 1'b1;
    n_rand  = 40;
    for (int k = 0; k < n_rand; k++) begin
      send(8'($urandom), w);
      repeat ($urandom_range(0, 3)) step();
    end
    en_rand = 1'b0;
    en      = 1'b1;
    repeat (30) step();
    check("random_words_done", wdc.size(), n_rand);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
